// File: rtl/minx_bus_responder.sv
`timescale 1ns/1ps
`default_nettype none
// minx_bus_responder: answers Minx core bus cycles from a 4 KiB internal RAM or an
// external req/ack memory port, stalling the core through clk_ce while an access is pending.
module minx_bus_responder #(
  parameter logic [23:0] RAM_BASE = 24'h001000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_ce_in,
  output logic        clk_ce,
  input  logic [23:0] address_in,
  input  logic [7:0]  data_in,
  input  logic [1:0]  bus_status,
  input  logic        read,
  input  logic        write,
  output logic [7:0]  data_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        bus_timeout
);

  localparam logic [1:0]  BUS_COMMAND_MEM_READ = 2'd3;
  localparam logic [23:0] BIOS_END             = 24'h001000;
  localparam logic [23:0] CART_BASE            = 24'h002100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RAMRD = 2'd1,
    S_EXT   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  wait_q, wait_d;
  logic        timeout_q, timeout_d;
  logic        stall;

  logic [7:0]  ram_mem [0:4095];
  logic [7:0]  ram_q;

  // Region decode; the register window and any unmapped gap fall through as unserviced.
  logic [23:0] ram_off;
  logic        in_ram, in_bios, in_cart;
  logic        rd_req, wr_req;
  logic        acc_ram_rd, acc_ram_wr, acc_ext;
  logic [7:0]  wait_inc;

  assign ram_off  = address_in - RAM_BASE;
  assign in_ram   = (address_in >= RAM_BASE) && (ram_off[23:12] == 12'h000);
  assign in_bios  = (address_in < BIOS_END);
  assign in_cart  = (address_in >= CART_BASE);

  assign rd_req   = read && (bus_status == BUS_COMMAND_MEM_READ);
  assign wr_req   = write && !rd_req;

  assign acc_ram_rd = (state_q == S_IDLE) && clk_ce_in && rd_req && in_ram;
  assign acc_ram_wr = (state_q == S_IDLE) && clk_ce_in && wr_req && in_ram;
  assign acc_ext    = (state_q == S_IDLE) && clk_ce_in && !in_ram &&
                      ((rd_req && (in_bios || in_cart)) || (wr_req && in_cart));

  assign wait_inc = wait_q + 8'd1;

  always_ff @(posedge clk) begin
    if (acc_ram_wr) begin
      ram_mem[ram_off[11:0]] <= data_in;
    end
    ram_q <= ram_mem[ram_off[11:0]];
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    wait_d      = wait_q;
    timeout_d   = 1'b0;
    stall       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc_ram_rd) begin
          stall   = 1'b1;
          state_d = S_RAMRD;
        end else if (acc_ext) begin
          stall       = 1'b1;
          state_d     = S_EXT;
          mem_req_d   = 1'b1;
          mem_we_d    = wr_req;
          mem_addr_d  = address_in;
          mem_wdata_d = wr_req ? data_in : 8'h00;
          wait_d      = 8'd0;
          if (wr_req) begin
            rdata_d = 8'h00;
          end
        end
      end
      S_RAMRD: begin
        stall   = 1'b1;
        rdata_d = ram_q;
        state_d = S_DONE;
      end
      S_EXT: begin
        stall = 1'b1;
        if (mem_ack) begin
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_DONE;
        end else if (wait_inc >= TIMEOUT) begin
          // Ack still missing after TIMEOUT request cycles: abort with a sentinel byte.
          rdata_d   = 8'hFF;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          timeout_d = 1'b1;
          wait_d    = wait_inc;
          state_d   = S_DONE;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_DONE: begin
        if (clk_ce_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 24'h000000;
      mem_wdata_q <= 8'h00;
      rdata_q     <= 8'h00;
      wait_q      <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
    end
  end

  // Zero outside DONE so the result can be OR-ed with the register window's data.
  assign data_out    = (state_q == S_DONE) ? rdata_q : 8'h00;
  assign clk_ce      = clk_ce_in && !stall;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign bus_timeout = timeout_q;

endmodule
`default_nettype wire
